// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output serializer.
package fft_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Mirror a 3-bit index: output order of a radix-2 DIT/DIF FFT
    function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// Parallel-frame capture and serial-stream handshake bundle of the serializer.
interface fft_out_serializer_if #(
    parameter int unsigned WIDTH = fft_pkg::WIDTH_DEF
);
    import fft_pkg::*;

    logic [WIDTH-1:0] in_0;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic [WIDTH-1:0] in_3;
    logic [WIDTH-1:0] in_4;
    logic [WIDTH-1:0] in_5;
    logic [WIDTH-1:0] in_6;
    logic [WIDTH-1:0] in_7;
    logic             load;
    logic             load_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
        output load, out_ready,
        input  load_ready, out_data, out_valid, out_idx, out_last
    );

    modport slave (
        input  in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
        input  load, out_ready,
        output load_ready, out_data, out_valid, out_idx, out_last
    );

endinterface

// File: rtl/fft_out_serializer.sv
// Captures an 8-sample FFT frame and streams it out one sample per handshake.
// Define FFT_BITREV_EN to emit samples in bit-reversed source order.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_out_serializer_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(DEPTH - 1);

    // Map beat number to the source sample index it carries
    function automatic logic [IDX_W-1:0] src_idx(input logic [IDX_W-1:0] k);
`ifdef FFT_BITREV_EN
        return bitrev3(k);
`else
        return k;
`endif
    endfunction

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic [WIDTH-1:0] in_c [DEPTH];
    logic [IDX_W-1:0] nxt_cnt_c;
    logic             last_hs_c;
    logic             load_ready_c;
    logic             capture_c;
    logic             beat_c;

    always_comb begin
        in_c[0] = bus.in_0;
        in_c[1] = bus.in_1;
        in_c[2] = bus.in_2;
        in_c[3] = bus.in_3;
        in_c[4] = bus.in_4;
        in_c[5] = bus.in_5;
        in_c[6] = bus.in_6;
        in_c[7] = bus.in_7;
    end

    // Accepting a frame on the last beat's handshake keeps the stream bubble-free
    always_comb begin
        last_hs_c    = out_valid_q & bus.out_ready & out_last_q;
        load_ready_c = (state_q == ST_IDLE) | last_hs_c;
        capture_c    = bus.load & load_ready_c;
        beat_c       = out_valid_q & bus.out_ready;
        nxt_cnt_c    = IDX_W'(cnt_q + IDX_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (capture_c) begin
            // Beat 0 comes straight from the inputs since the buffer loads on this edge
            state_q     <= ST_SEND;
            cnt_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= in_c[i];
            out_data_q  <= in_c[src_idx(IDX_W'(0))];
            out_idx_q   <= src_idx(IDX_W'(0));
            out_valid_q <= 1'b1;
            out_last_q  <= (LAST_BEAT == IDX_W'(0));
        end else if (beat_c) begin
            if (out_last_q) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
            end else begin
                cnt_q      <= nxt_cnt_c;
                out_data_q <= buf_q[src_idx(nxt_cnt_c)];
                out_idx_q  <= src_idx(nxt_cnt_c);
                out_last_q <= (nxt_cnt_c == LAST_BEAT);
            end
        end
    end

    assign bus.load_ready = load_ready_c;
    assign bus.out_data   = out_data_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: frame-level reference model plus directed frame scenarios.
module tb_fft_out_serializer;
    import fft_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_out_serializer_if #(.WIDTH(W)) bus ();

    fft_out_serializer #(.WIDTH(W), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] din [8];
    logic         load   = 1'b0;
    logic         oready = 1'b0;

    assign bus.in_0      = din[0];
    assign bus.in_1      = din[1];
    assign bus.in_2      = din[2];
    assign bus.in_3      = din[3];
    assign bus.in_4      = din[4];
    assign bus.in_5      = din[5];
    assign bus.in_6      = din[6];
    assign bus.in_7      = din[7];
    assign bus.load      = load;
    assign bus.out_ready = oready;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected emission order of source samples
    function automatic int ord(input int k);
`ifdef FFT_BITREV_EN
        int t [8];
        t = '{0, 4, 2, 6, 1, 5, 3, 7};
        return t[k];
`else
        return k;
`endif
    endfunction

    // Frame-level model: the captured frame and which beat is on the wire
    logic [W-1:0] mframe [8];
    int           mpos   = 0;
    bit           mvalid = 1'b0;

    initial foreach (mframe[i]) mframe[i] = '0;

    always @(posedge clk or negedge rst_n) begin
        bit lr;
        if (!rst_n) begin
            foreach (mframe[i]) mframe[i] = '0;
            mpos   = 0;
            mvalid = 1'b0;
        end else begin
            lr = !mvalid || (oready && mpos == 7);
            if (load && lr) begin
                foreach (mframe[i]) mframe[i] = din[i];
                mpos   = 0;
                mvalid = 1'b1;
            end else if (mvalid && oready) begin
                if (mpos == 7) mvalid = 1'b0;
                else           mpos++;
            end
        end
    end

    logic [W-1:0] gotq [$];
    logic [2:0]   idxq [$];
    bit           lastq [$];
    int           vcount = 0;

    always @(negedge clk) begin
        check("out_valid",  32'(bus.out_valid),  32'(mvalid));
        check("load_ready", 32'(bus.load_ready), 32'(!mvalid || (oready && mpos == 7)));
        check("out_last",   32'(bus.out_last),   32'(mpos == 7));
        check("out_data",   32'(bus.out_data),   32'(mframe[ord(mpos)]));
        check("out_idx",    32'(bus.out_idx),    32'(ord(mpos)));
        if (bus.out_valid) vcount++;
        if (bus.out_valid && oready) begin
            gotq.push_back(bus.out_data);
            idxq.push_back(bus.out_idx);
            lastq.push_back(bus.out_last);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_frame(input logic [W-1:0] base);
        for (int k = 0; k < 8; k++) din[k] = W'(base + W'(k));
    endtask

    task automatic clear_log();
        gotq.delete();
        idxq.delete();
        lastq.delete();
        vcount = 0;
    endtask

    task automatic expect_frame(input string name, input logic [W-1:0] base, input int first);
        for (int k = 0; k < 8; k++) begin
            if (first + k < gotq.size())
                check(name, 32'(gotq[first + k]), 32'(W'(base + W'(ord(k)))));
            else
                check({name, " missing beat"}, 32'(gotq.size()), 32'(first + k + 1));
        end
    endtask

    initial begin
        foreach (din[i]) din[i] = '0;
        tick(2);
        check("reset out_valid",  32'(bus.out_valid),  32'd0);
        check("reset load_ready", 32'(bus.load_ready), 32'd1);
        check("reset out_data",   32'(bus.out_data),   32'd0);
        check("reset out_idx",    32'(bus.out_idx),    32'd0);
        check("reset out_last",   32'(bus.out_last),   32'd0);
        rst_n = 1'b1;

        // Single frame, always ready
        clear_log();
        set_frame(16'h0100);
        load = 1'b1; oready = 1'b1;
        tick(1);
        load = 1'b0;
        check("A first beat", 32'(bus.out_data), 32'(16'h0100));
        tick(10);
        check("A beats", 32'(gotq.size()), 32'd8);
        expect_frame("A data", 16'h0100, 0);
        for (int k = 0; k < 8 && k < lastq.size(); k++)
            check("A out_last", 32'(lastq[k]), 32'(k == 7));
        check("A valid after", 32'(bus.out_valid), 32'd0);
        check("A valid cycles", 32'(vcount), 32'd8);

        // Ready toggling: each sample waits one stalled cycle
        clear_log();
        set_frame(16'h0100);
        load = 1'b1; oready = 1'b0;
        tick(1);
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            oready = (i % 2 == 1);
            tick(1);
        end
        oready = 1'b1;
        tick(2);
        check("B beats", 32'(gotq.size()), 32'd8);
        expect_frame("B data", 16'h0100, 0);
        check("B valid cycles", 32'(vcount), 32'd16);

        // load held high across two frames: back-to-back
        clear_log();
        set_frame(16'h0100);
        load = 1'b1; oready = 1'b1;
        tick(1);
        set_frame(16'h0200);
        tick(7);
        check("C beat 7 data", 32'(bus.out_data), 32'(16'h0107));
        check("C beat 7 last", 32'(bus.out_last), 32'd1);
        tick(1);
        load = 1'b0;
        check("C no bubble valid", 32'(bus.out_valid), 32'd1);
        check("C no bubble data",  32'(bus.out_data),  32'(16'h0200));
        tick(10);
        check("C beats", 32'(gotq.size()), 32'd16);
        expect_frame("C frame1", 16'h0100, 0);
        expect_frame("C frame2", 16'h0200, 8);
        check("C valid cycles", 32'(vcount), 32'd16);

        // load mid-frame is ignored and input changes do not leak in
        clear_log();
        set_frame(16'h0100);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(3);
        set_frame(16'h0300);
        load = 1'b1;
        #1;
        check("D beat idx", 32'(bus.out_idx), 32'(ord(3)));
        check("D load_ready", 32'(bus.load_ready), 32'd0);
        tick(1);
        load = 1'b0;
        tick(10);
        check("D beats", 32'(gotq.size()), 32'd8);
        expect_frame("D data", 16'h0100, 0);

        // Reset in beat 4 discards the rest of the frame
        clear_log();
        set_frame(16'h0100);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(4);
        check("E beat 4 data", 32'(bus.out_data), 32'(W'(16'h0100 + W'(ord(4)))));
        rst_n = 1'b0;
        #1;
        check("E rst out_valid",  32'(bus.out_valid),  32'd0);
        check("E rst out_data",   32'(bus.out_data),   32'd0);
        check("E rst load_ready", 32'(bus.load_ready), 32'd1);
        tick(1);
        rst_n = 1'b1;
        check("E partial beats", 32'(gotq.size()), 32'd4);
        clear_log();
        tick(2);
        check("E no resume", 32'(vcount), 32'd0);
        set_frame(16'h0500);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        check("E restart idx", 32'(bus.out_idx), 32'd0);
        tick(10);
        check("E beats", 32'(gotq.size()), 32'd8);
        expect_frame("E data", 16'h0500, 0);

        // Emission order with in_k = k
        clear_log();
        set_frame(16'h0000);
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(10);
        begin
            int exp_order [8];
`ifdef FFT_BITREV_EN
            exp_order = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
            exp_order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
            check("F beats", 32'(gotq.size()), 32'd8);
            for (int k = 0; k < 8 && k < gotq.size(); k++) begin
                check("F order data", 32'(gotq[k]), 32'(exp_order[k]));
                check("F order idx",  32'(idxq[k]), 32'(exp_order[k]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
